// File: rtl/io_port_decoder_if.sv
// rtl/io_port_decoder_if.sv - processor-side I/O bus between CPU/peripherals and the port decoder
interface io_port_decoder_if #(
    parameter int ADRS_W  = 16,
    parameter int N_PORTS = 8,
    parameter int DATA_W  = 8
);
    logic [ADRS_W-1:0]         port_id;
    logic                      write_strobe;
    logic                      read_strobe;
    logic [N_PORTS*DATA_W-1:0] rd_data_bus;
    logic                      err_clr;
    logic [N_PORTS-1:0]        writes;
    logic [N_PORTS-1:0]        reads;
    logic [DATA_W-1:0]         in_port;
    logic [7:0]                miss_cnt;
    logic                      err;

    modport master (
        output port_id, write_strobe, read_strobe, rd_data_bus, err_clr,
        input  writes, reads, in_port, miss_cnt, err
    );

    modport slave (
        input  port_id, write_strobe, read_strobe, rd_data_bus, err_clr,
        output writes, reads, in_port, miss_cnt, err
    );
endinterface

// File: rtl/io_port_decoder.sv
// rtl/io_port_decoder.sv - registered base/mask I/O port decoder with one pulse per bus access
module io_port_decoder #(
    parameter int               ADRS_W  = 16,
    parameter int               SEL_W   = 3,
    parameter int               N_PORTS = 8,
    parameter int               DATA_W  = 8,
    parameter logic [ADRS_W-1:0] BASE   = 16'h0000,
    parameter logic [ADRS_W-1:0] MASK   = 16'h8000
) (
    input  logic                clk,
    input  logic                reset_n,
    io_port_decoder_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, WR_HOLD, RD_HOLD, ERR_HOLD} state_t;

    state_t              r_state;
    logic [N_PORTS-1:0]  r_writes;
    logic [N_PORTS-1:0]  r_reads;
    logic [DATA_W-1:0]   r_in_port;
    logic [7:0]          r_miss_cnt;
    logic                r_err;

    state_t              w_state_nxt;
    logic [N_PORTS-1:0]  w_writes_nxt;
    logic [N_PORTS-1:0]  w_reads_nxt;
    logic [DATA_W-1:0]   w_in_port_nxt;
    logic [7:0]          w_miss_cnt_nxt;
    logic                w_err_nxt;

    logic [SEL_W-1:0]    w_sel;
    logic                w_hit;
    logic                w_valid;
    logic [N_PORTS-1:0]  w_onehot;
    logic [DATA_W-1:0]   w_rd_data;
    logic                w_ws;
    logic                w_rs;

    assign w_ws    = bus.write_strobe;
    assign w_rs    = bus.read_strobe;
    assign w_sel   = bus.port_id[SEL_W-1:0];
    assign w_hit   = ((bus.port_id ^ BASE) & MASK) == '0;
    assign w_valid = w_hit && ({1'b0, w_sel} < (SEL_W+1)'(N_PORTS));

    always_comb begin
        w_onehot  = '0;
        w_rd_data = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            if (w_sel == SEL_W'(k)) begin
                w_onehot[k] = 1'b1;
                w_rd_data   = bus.rd_data_bus[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_writes_nxt   = '0;
        w_reads_nxt    = '0;
        w_in_port_nxt  = r_in_port;
        w_miss_cnt_nxt = r_miss_cnt;
        w_err_nxt      = r_err;

        case (r_state)
            IDLE: begin
                if (w_ws && w_rs) begin
                    w_state_nxt = ERR_HOLD;
                    w_err_nxt   = 1'b1;
                end else if (w_ws) begin
                    w_state_nxt = WR_HOLD;
                    if (w_valid)
                        w_writes_nxt = w_onehot;
                    else if (r_miss_cnt != 8'hFF)
                        w_miss_cnt_nxt = r_miss_cnt + 8'd1;
                end else if (w_rs) begin
                    w_state_nxt = RD_HOLD;
                    if (w_valid) begin
                        w_reads_nxt   = w_onehot;
                        w_in_port_nxt = w_rd_data;
                    end else if (r_miss_cnt != 8'hFF) begin
                        w_miss_cnt_nxt = r_miss_cnt + 8'd1;
                    end
                end
            end
            // Any strobe activity while holding belongs to the access already accepted.
            WR_HOLD, RD_HOLD, ERR_HOLD: begin
                if (!(w_ws || w_rs))
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase

        if (bus.err_clr) begin
            w_err_nxt      = 1'b0;
            w_miss_cnt_nxt = 8'h00;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_writes   <= '0;
            r_reads    <= '0;
            r_in_port  <= '0;
            r_miss_cnt <= 8'h00;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_writes   <= w_writes_nxt;
            r_reads    <= w_reads_nxt;
            r_in_port  <= w_in_port_nxt;
            r_miss_cnt <= w_miss_cnt_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign bus.writes   = r_writes;
    assign bus.reads    = r_reads;
    assign bus.in_port  = r_in_port;
    assign bus.miss_cnt = r_miss_cnt;
    assign bus.err      = r_err;
endmodule

// File: tb/tb_io_port_decoder.sv
// tb/tb_io_port_decoder.sv - directed checks of io_port_decoder at default and narrowed parameters
module tb_io_port_decoder;
    localparam int B_PORTS = 5;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    io_port_decoder_if #(.ADRS_W(16), .N_PORTS(8), .DATA_W(8))       a_if ();
    io_port_decoder_if #(.ADRS_W(16), .N_PORTS(B_PORTS), .DATA_W(8)) b_if ();

    io_port_decoder u_dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (a_if.slave)
    );

    io_port_decoder #(
        .N_PORTS (B_PORTS),
        .BASE    (16'h0040),
        .MASK    (16'hFFF8)
    ) u_dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b_if.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_a_quiet(input string tag);
        chk({tag, ".writes"}, 32'(a_if.writes), 32'h0);
        chk({tag, ".reads"},  32'(a_if.reads),  32'h0);
    endtask

    initial begin
        a_if.port_id = '0; a_if.write_strobe = 0; a_if.read_strobe = 0;
        a_if.rd_data_bus = '0; a_if.err_clr = 0;
        b_if.port_id = '0; b_if.write_strobe = 0; b_if.read_strobe = 0;
        b_if.rd_data_bus = '0; b_if.err_clr = 0;

        // Reset held with strobes toggling
        a_if.port_id = 16'h0001;
        a_if.rd_data_bus = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            a_if.write_strobe = i[0];
            a_if.read_strobe  = ~i[0];
            tick();
            chk_a_quiet("rst_hold");
            chk("rst_hold.in_port",  32'(a_if.in_port),  32'h0);
            chk("rst_hold.miss_cnt", 32'(a_if.miss_cnt), 32'h0);
            chk("rst_hold.err",      32'(a_if.err),      32'h0);
        end
        a_if.write_strobe = 0; a_if.read_strobe = 0;
        a_if.rd_data_bus = '0;
        tick();
        reset_n = 1'b1;
        tick();
        chk_a_quiet("rst_release");

        // Single-cycle write to port 5
        a_if.port_id = 16'h0005; a_if.write_strobe = 1;
        tick();
        chk("wr5.writes", 32'(a_if.writes), 32'h20);
        chk("wr5.reads",  32'(a_if.reads),  32'h00);
        a_if.write_strobe = 0;
        tick();
        chk_a_quiet("wr5.after");

        // Held write with a read rising in WR_HOLD: one pulse, no err
        a_if.port_id = 16'h0003; a_if.write_strobe = 1;
        tick();
        chk("wrhold.writes", 32'(a_if.writes), 32'h08);
        a_if.read_strobe = 1; a_if.port_id = 16'h0006;
        tick();
        chk_a_quiet("wrhold.rs_rise");
        chk("wrhold.err", 32'(a_if.err), 32'h0);
        a_if.write_strobe = 0;
        tick();
        chk_a_quiet("wrhold.rs_only");
        a_if.read_strobe = 0;
        tick();

        // Held read of port 2; later bus changes ignored
        a_if.port_id = 16'h0002; a_if.rd_data_bus = 64'h0000_0000_00A5_0000;
        a_if.read_strobe = 1;
        tick();
        chk("rd2.reads",   32'(a_if.reads),   32'h04);
        chk("rd2.writes",  32'(a_if.writes),  32'h00);
        chk("rd2.in_port", 32'(a_if.in_port), 32'hA5);
        a_if.rd_data_bus = 64'h0000_0000_005A_0000; a_if.port_id = 16'h0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_a_quiet("rd2.hold");
            chk("rd2.hold.in_port", 32'(a_if.in_port), 32'hA5);
        end
        a_if.read_strobe = 0;
        tick();
        chk("rd2.idle.in_port", 32'(a_if.in_port), 32'hA5);

        // Out-of-window write, repeated past saturation
        a_if.port_id = 16'h8003;
        for (int i = 1; i <= 300; i++) begin
            a_if.write_strobe = 1;
            tick();
            if (i == 1 || i == 254 || i == 255 || i == 300) begin
                chk("miss.writes", 32'(a_if.writes), 32'h0);
                chk("miss.cnt", 32'(a_if.miss_cnt), (i > 255) ? 32'hFF : 32'(i));
            end
            a_if.write_strobe = 0;
            tick();
        end
        a_if.err_clr = 1;
        tick();
        a_if.err_clr = 0;
        chk("miss.clr", 32'(a_if.miss_cnt), 32'h0);

        // Missed read keeps in_port; clear wins over a coincident miss
        a_if.read_strobe = 1;
        tick();
        chk("missrd.cnt",     32'(a_if.miss_cnt), 32'h1);
        chk("missrd.in_port", 32'(a_if.in_port),  32'hA5);
        a_if.read_strobe = 0;
        tick();
        a_if.write_strobe = 1; a_if.err_clr = 1;
        tick();
        chk("clrwin.cnt", 32'(a_if.miss_cnt), 32'h0);
        a_if.write_strobe = 0; a_if.err_clr = 0;
        tick();

        // Collision
        a_if.port_id = 16'h0000; a_if.write_strobe = 1; a_if.read_strobe = 1;
        tick();
        chk_a_quiet("coll");
        chk("coll.err",  32'(a_if.err),      32'h1);
        chk("coll.miss", 32'(a_if.miss_cnt), 32'h0);
        a_if.read_strobe = 0;
        tick();
        chk_a_quiet("coll.hold");
        a_if.write_strobe = 0;
        tick();
        chk("coll.sticky", 32'(a_if.err), 32'h1);
        a_if.write_strobe = 1;
        tick();
        chk("coll.nextwr", 32'(a_if.writes), 32'h01);
        chk("coll.nextwr.err", 32'(a_if.err), 32'h1);
        a_if.write_strobe = 0; a_if.err_clr = 1;
        tick();
        a_if.err_clr = 0;
        chk("coll.clr", 32'(a_if.err), 32'h0);
        a_if.write_strobe = 1; a_if.read_strobe = 1; a_if.err_clr = 1;
        tick();
        chk("coll.clrwin", 32'(a_if.err), 32'h0);
        a_if.write_strobe = 0; a_if.read_strobe = 0; a_if.err_clr = 0;
        tick();

        // Reset in the middle of a held read
        a_if.port_id = 16'h0001; a_if.rd_data_bus = 64'h0000_0000_0000_3C00;
        a_if.read_strobe = 1;
        tick();
        chk("rstmid.reads",   32'(a_if.reads),   32'h02);
        chk("rstmid.in_port", 32'(a_if.in_port), 32'h3C);
        reset_n = 1'b0;
        #1;
        chk("rstmid.async.in_port", 32'(a_if.in_port), 32'h0);
        chk_a_quiet("rstmid.async");
        tick();
        reset_n = 1'b1;
        tick();
        chk("rstmid.again.reads",   32'(a_if.reads),   32'h02);
        chk("rstmid.again.in_port", 32'(a_if.in_port), 32'h3C);
        a_if.read_strobe = 0;
        tick();
        chk_a_quiet("rstmid.done");

        // Narrowed instance: 5 ports at base 0x0040
        b_if.port_id = 16'h0044; b_if.write_strobe = 1;
        tick();
        chk("b.wr44", 32'(b_if.writes), 32'h10);
        b_if.write_strobe = 0;
        tick();
        b_if.port_id = 16'h0046; b_if.write_strobe = 1;
        tick();
        chk("b.wr46.writes", 32'(b_if.writes), 32'h0);
        chk("b.wr46.miss",   32'(b_if.miss_cnt), 32'h1);
        b_if.write_strobe = 0;
        tick();
        b_if.port_id = 16'h0084; b_if.write_strobe = 1;
        tick();
        chk("b.wr84.writes", 32'(b_if.writes), 32'h0);
        chk("b.wr84.miss",   32'(b_if.miss_cnt), 32'h2);
        b_if.write_strobe = 0;
        tick();
        b_if.port_id = 16'h0040; b_if.rd_data_bus = 40'h11_22_33_44_C7;
        b_if.read_strobe = 1;
        tick();
        chk("b.rd40.reads",   32'(b_if.reads),   32'h01);
        chk("b.rd40.in_port", 32'(b_if.in_port), 32'hC7);
        b_if.read_strobe = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
